vtage_update_ctrl_mp: RTL and testbench
=======================================

// Module: vtage_update_ctrl_mp
// PURPOSE
//  Multi-lane successor of the VTAGE update unit. Accepts up to P_NUM_FB retire feedbacks per cycle into a FIFO.
//  Drains the FIFO one entry at a time through an FSM that issues bank update commands over a valid/ready port:
//  confidence and useful updates, value reload, and tagged allocation into banks above the provider.
//  Sits between the commit feedback path and the VTAGE bank array; bank 0 is the untagged base table.
// PARAMETERS
//  P_NUM_FB       2   feedback lanes per cycle
//  P_NUM_BANK     4   banks (bank 0 base, 1..N-1 tagged)
//  P_NUM_ENTRIES  256 entries per bank; LP_INDEX_WIDTH=$clog2(P_NUM_ENTRIES)
//  P_CONF_WIDTH   3   confidence counter width; LP_CONF_MAX=2**P_CONF_WIDTH-1
//  P_TAG_WIDTH    12  tag width
//  P_U_WIDTH      2   useful counter width
//  P_VALUE_WIDTH  64  predicted value width
//  P_FIFO_DEPTH   8   feedback FIFO entries (power of 2, >= P_NUM_FB)
//  P_AGE_LOG2     8   ageing period = 2**P_AGE_LOG2 dequeued mispredicts
// PORTS
//  clk_i              in  1                          clock
//  rst_i              in  1                          synchronous active-high reset
//  fb_valid_i         in  P_NUM_FB                   lane valid
//  fb_ready_o         out 1                          all lanes accepted this cycle
//  fb_actual_i        in  P_NUM_FB*P_VALUE_WIDTH     committed value
//  fb_conf_i          in  P_NUM_FB*P_CONF_WIDTH      provider conf at predict time
//  fb_bank_i          in  P_NUM_FB*LP_BANK_SEL_WIDTH provider bank
//  fb_index_i         in  P_NUM_FB*P_NUM_BANK*LP_INDEX_WIDTH  per-bank index
//  fb_tag_i           in  P_NUM_FB*P_NUM_BANK*P_TAG_WIDTH     per-bank tag
//  fb_mispredict_i    in  P_NUM_FB                   prediction was wrong
//  bank_alloc_avail_i in  P_NUM_BANK                 useful==0 at the dequeued entry's index, per bank
//  ud_valid_o         out 1                          command valid
//  ud_ready_i         in  1                          bank array accepts command
//  ud_bank_o          out LP_BANK_SEL_WIDTH          target bank
//  ud_bank_mask_o     out P_NUM_BANK                 target mask for ud_decr_use_o
//  ud_index_o         out LP_INDEX_WIDTH             target index
//  ud_tag_o           out P_TAG_WIDTH                tag to load
//  ud_value_o         out P_VALUE_WIDTH              value to load
//  ud_conf_o          out P_CONF_WIDTH               new confidence
//  ud_incr_conf_o/ud_rst_conf_o/ud_incr_use_o/ud_decr_use_o/ud_rst_use_o/ud_load_tag_o/ud_load_value_o  out 1 op flags
//  ud_age_o           out 1                          global useful halving command
// BEHAVIOUR
//  Reset: FIFO empty, FSM IDLE, age counter 0. All ud_* outputs 0; fb_ready_o 1.
//  Reset mid-operation drops queued feedback and any pending command.
//  Enqueue:
//   fb_ready_o=1 iff free slots >= P_NUM_FB (registered, from current occupancy).
//   When ready, valid lanes enqueue in lane order; lane 0 is oldest. Invalid lanes are compressed out.
//   Lanes presented while not ready are ignored; the upstream holds them.
//  FIFO: pointers wrap modulo P_FIFO_DEPTH. Simultaneous enqueue and dequeue is allowed; occupancy = old + n_enq - deq.
//  FSM IDLE->UPD when FIFO non-empty. Head is latched; latch-to-first-command latency is 1 cycle.
//  UPD, correct prediction:
//   Command {bank=provider, incr_conf, conf=sat(conf+1,LP_CONF_MAX)}.
//   incr_use is also set when the new conf equals LP_CONF_MAX.
//   On accept -> IDLE.
//  UPD, mispredict:
//   Command {bank=provider, rst_conf, conf=0, load_value, value=actual}.
//   On accept -> ALLOC if provider<P_NUM_BANK-1, else -> IDLE.
//  ALLOC: bank_alloc_avail_i is sampled in ALLOC.
//   Target = lowest bank b>provider with avail[b]=1.
//   If found: {bank=b, load_tag, load_value, rst_conf, rst_use, index/tag of b}.
//   If not found: {decr_use, ud_bank_mask_o = banks >provider}.
//   On accept -> IDLE.
//  Every command holds all fields stable while ud_valid_o=1 && ud_ready_i=0. One command per handshake.
//  Unused op flags and fields are driven 0.
// CONFIGURATION
//  VTAGE_UD_AGEING_EN defined:
//   The age counter increments on each dequeued mispredict.
//   On wrap to 0, FSM enters AGE after the current command and issues one {ud_age_o=1} command before IDLE.
//  Undefined: no counter, no AGE state, ud_age_o tied 0.
// TESTING
//  1. Reset, 1 lane correct, conf=6, bank 2 -> one command bank2, incr_conf, conf=7, incr_use=1.
//  2. Mispredict bank 1, avail=4'b1000 -> cmd1 bank1 rst_conf+load_value; cmd2 bank3 alloc with tag/index of lane bank3.
//  3. Mispredict bank 1, avail=0 -> cmd2 decr_use, ud_bank_mask_o=4'b1100.
//  4. Both lanes valid every cycle, ud_ready_i=0 -> 8 queued, fb_ready_o=0 at occupancy 7; no loss and in-order drain after release.
//  5. Backpressure: ud_ready_i toggling -> command fields stable while stalled; rst_i mid-ALLOC -> ud_valid_o=0 next cycle, FIFO empty.
//  6. With VTAGE_UD_AGEING_EN and P_AGE_LOG2=2: 4 mispredicts -> exactly one ud_age_o command after the 4th.

Source files
------------

// File: rtl/vtage_update_ctrl_mp.sv
// VTAGE multi-lane update controller: feedback FIFO drained by an FSM issuing bank update commands.
// Optional global useful-counter ageing is built when VTAGE_UD_AGEING_EN is defined.
module vtage_update_ctrl_mp #(
  parameter  int unsigned P_NUM_FB          = 2,
  parameter  int unsigned P_NUM_BANK        = 4,
  parameter  int unsigned P_NUM_ENTRIES     = 256,
  parameter  int unsigned P_CONF_WIDTH      = 3,
  parameter  int unsigned P_TAG_WIDTH       = 12,
  parameter  int unsigned P_U_WIDTH         = 2,
  parameter  int unsigned P_VALUE_WIDTH     = 64,
  parameter  int unsigned P_FIFO_DEPTH      = 8,
  parameter  int unsigned P_AGE_LOG2        = 8,
  localparam int unsigned LP_INDEX_WIDTH    = $clog2(P_NUM_ENTRIES),
  localparam int unsigned LP_BANK_SEL_WIDTH = $clog2(P_NUM_BANK)
) (
  input  logic                                            clk_i,
  input  logic                                            rst_i,
  input  logic [P_NUM_FB-1:0]                             fb_valid_i,
  output logic                                            fb_ready_o,
  input  logic [P_NUM_FB*P_VALUE_WIDTH-1:0]               fb_actual_i,
  input  logic [P_NUM_FB*P_CONF_WIDTH-1:0]                fb_conf_i,
  input  logic [P_NUM_FB*LP_BANK_SEL_WIDTH-1:0]           fb_bank_i,
  input  logic [P_NUM_FB*P_NUM_BANK*LP_INDEX_WIDTH-1:0]   fb_index_i,
  input  logic [P_NUM_FB*P_NUM_BANK*P_TAG_WIDTH-1:0]      fb_tag_i,
  input  logic [P_NUM_FB-1:0]                             fb_mispredict_i,
  input  logic [P_NUM_BANK-1:0]                           bank_alloc_avail_i,
  output logic                                            ud_valid_o,
  input  logic                                            ud_ready_i,
  output logic [LP_BANK_SEL_WIDTH-1:0]                    ud_bank_o,
  output logic [P_NUM_BANK-1:0]                           ud_bank_mask_o,
  output logic [LP_INDEX_WIDTH-1:0]                       ud_index_o,
  output logic [P_TAG_WIDTH-1:0]                          ud_tag_o,
  output logic [P_VALUE_WIDTH-1:0]                        ud_value_o,
  output logic [P_CONF_WIDTH-1:0]                         ud_conf_o,
  output logic                                            ud_incr_conf_o,
  output logic                                            ud_rst_conf_o,
  output logic                                            ud_incr_use_o,
  output logic                                            ud_decr_use_o,
  output logic                                            ud_rst_use_o,
  output logic                                            ud_load_tag_o,
  output logic                                            ud_load_value_o,
  output logic                                            ud_age_o
);

  localparam int unsigned LP_CONF_MAX = 2**P_CONF_WIDTH - 1;
  localparam int unsigned LP_PTR_W    = $clog2(P_FIFO_DEPTH);
  localparam int unsigned LP_CNT_W    = LP_PTR_W + 1;
  localparam int unsigned LP_TOP_BANK = P_NUM_BANK - 1;

  typedef struct packed {
    logic [P_VALUE_WIDTH-1:0]             actual;
    logic [P_CONF_WIDTH-1:0]              conf;
    logic [LP_BANK_SEL_WIDTH-1:0]         bank;
    logic [P_NUM_BANK*LP_INDEX_WIDTH-1:0] index;
    logic [P_NUM_BANK*P_TAG_WIDTH-1:0]    tag;
    logic                                 mispred;
  } fb_entry_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_UPD   = 2'd1,
`ifdef VTAGE_UD_AGEING_EN
    S_ALLOC = 2'd2,
    S_AGE   = 2'd3
`else
    S_ALLOC = 2'd2
`endif
  } state_t;

  fb_entry_t                  r_mem [P_FIFO_DEPTH];
  logic [LP_PTR_W-1:0]        r_wr_ptr;
  logic [LP_PTR_W-1:0]        r_rd_ptr;
  logic [LP_CNT_W-1:0]        r_count;
  fb_entry_t                  r_cur;
  state_t                     r_state;
  state_t                     w_state_nxt;
  state_t                     w_done_state;
  logic                       r_avail_vld;
  logic [P_NUM_BANK-1:0]      r_avail_hold;

  fb_entry_t                  w_lane [P_NUM_FB];
  logic [P_NUM_FB-1:0]        w_wen;
  logic [LP_PTR_W-1:0]        w_slot [P_NUM_FB];
  logic [LP_CNT_W-1:0]        w_n_enq;
  logic                       w_fb_ready;
  logic                       w_deq;

  logic [P_NUM_BANK-1:0]      w_avail;
  logic [LP_INDEX_WIDTH-1:0]  w_prov_idx;
  logic                       w_found;
  logic [LP_BANK_SEL_WIDTH-1:0] w_tgt;
  logic [LP_INDEX_WIDTH-1:0]  w_tgt_idx;
  logic [P_TAG_WIDTH-1:0]     w_tgt_tag;
  logic [P_NUM_BANK-1:0]      w_upper_mask;
  logic [P_CONF_WIDTH-1:0]    w_conf_sat;

  logic                       w_ud_valid;
  logic [LP_BANK_SEL_WIDTH-1:0] w_ud_bank;
  logic [P_NUM_BANK-1:0]      w_ud_mask;
  logic [LP_INDEX_WIDTH-1:0]  w_ud_index;
  logic [P_TAG_WIDTH-1:0]     w_ud_tag;
  logic [P_VALUE_WIDTH-1:0]   w_ud_value;
  logic [P_CONF_WIDTH-1:0]    w_ud_conf;
  logic                       w_incr_conf;
  logic                       w_rst_conf;
  logic                       w_incr_use;
  logic                       w_decr_use;
  logic                       w_rst_use;
  logic                       w_load_tag;
  logic                       w_load_value;
  logic                       w_age;

  // Unpack the flat lane buses into entries.
  always_comb begin
    for (int unsigned l = 0; l < P_NUM_FB; l++) begin
      w_lane[l].actual  = fb_actual_i[l*P_VALUE_WIDTH +: P_VALUE_WIDTH];
      w_lane[l].conf    = fb_conf_i[l*P_CONF_WIDTH +: P_CONF_WIDTH];
      w_lane[l].bank    = fb_bank_i[l*LP_BANK_SEL_WIDTH +: LP_BANK_SEL_WIDTH];
      w_lane[l].index   = fb_index_i[l*P_NUM_BANK*LP_INDEX_WIDTH +: P_NUM_BANK*LP_INDEX_WIDTH];
      w_lane[l].tag     = fb_tag_i[l*P_NUM_BANK*P_TAG_WIDTH +: P_NUM_BANK*P_TAG_WIDTH];
      w_lane[l].mispred = fb_mispredict_i[l];
    end
  end

  // Valid lanes take consecutive slots in lane order, so invalid lanes leave no holes.
  always_comb begin
    w_fb_ready = (LP_CNT_W'(P_FIFO_DEPTH) - r_count) >= LP_CNT_W'(P_NUM_FB);
    w_n_enq    = '0;
    for (int unsigned l = 0; l < P_NUM_FB; l++) begin
      w_slot[l] = r_wr_ptr + w_n_enq[LP_PTR_W-1:0];
      w_wen[l]  = w_fb_ready && fb_valid_i[l];
      if (w_wen[l]) w_n_enq = w_n_enq + 1'b1;
    end
  end

  assign w_deq = (r_state == S_IDLE) && (r_count != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + w_n_enq[LP_PTR_W-1:0];
      r_rd_ptr <= r_rd_ptr + LP_PTR_W'(w_deq);
      r_count  <= r_count + w_n_enq - LP_CNT_W'(w_deq);
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned l = 0; l < P_NUM_FB; l++) begin
      if (w_wen[l]) r_mem[w_slot[l]] <= w_lane[l];
    end
    if (w_deq) r_cur <= r_mem[r_rd_ptr];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Availability is taken live on the first ALLOC cycle and frozen while stalled,
  // so the chosen target cannot move under backpressure.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_avail_vld  <= 1'b0;
      r_avail_hold <= '0;
    end else if (r_state == S_ALLOC && !ud_ready_i) begin
      r_avail_vld <= 1'b1;
      if (!r_avail_vld) r_avail_hold <= bank_alloc_avail_i;
    end else begin
      r_avail_vld <= 1'b0;
    end
  end

  assign w_avail = r_avail_vld ? r_avail_hold : bank_alloc_avail_i;

`ifdef VTAGE_UD_AGEING_EN
  logic [P_AGE_LOG2-1:0] r_age_cnt;
  logic                  r_age_pend;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_age_cnt  <= '0;
      r_age_pend <= 1'b0;
    end else begin
      if (w_deq && r_mem[r_rd_ptr].mispred) begin
        r_age_cnt <= r_age_cnt + 1'b1;
        if (r_age_cnt == '1) r_age_pend <= 1'b1;
      end
      if (r_state == S_AGE && ud_ready_i) r_age_pend <= 1'b0;
    end
  end

  assign w_done_state = r_age_pend ? S_AGE : S_IDLE;
`else
  assign w_done_state = S_IDLE;
`endif

  // Provider index, lowest available bank above the provider, and the upper-bank mask.
  always_comb begin
    w_prov_idx   = '0;
    w_found      = 1'b0;
    w_tgt        = '0;
    w_tgt_idx    = '0;
    w_tgt_tag    = '0;
    w_upper_mask = '0;
    for (int unsigned b = 0; b < P_NUM_BANK; b++) begin
      if (LP_BANK_SEL_WIDTH'(b) == r_cur.bank)
        w_prov_idx = r_cur.index[b*LP_INDEX_WIDTH +: LP_INDEX_WIDTH];
      w_upper_mask[b] = LP_BANK_SEL_WIDTH'(b) > r_cur.bank;
      if (!w_found && w_upper_mask[b] && w_avail[b]) begin
        w_found   = 1'b1;
        w_tgt     = LP_BANK_SEL_WIDTH'(b);
        w_tgt_idx = r_cur.index[b*LP_INDEX_WIDTH +: LP_INDEX_WIDTH];
        w_tgt_tag = r_cur.tag[b*P_TAG_WIDTH +: P_TAG_WIDTH];
      end
    end
  end

  assign w_conf_sat = (r_cur.conf == P_CONF_WIDTH'(LP_CONF_MAX)) ? r_cur.conf
                                                                : r_cur.conf + 1'b1;

  always_comb begin
    w_state_nxt  = r_state;
    w_ud_valid   = 1'b0;
    w_ud_bank    = '0;
    w_ud_mask    = '0;
    w_ud_index   = '0;
    w_ud_tag     = '0;
    w_ud_value   = '0;
    w_ud_conf    = '0;
    w_incr_conf  = 1'b0;
    w_rst_conf   = 1'b0;
    w_incr_use   = 1'b0;
    w_decr_use   = 1'b0;
    w_rst_use    = 1'b0;
    w_load_tag   = 1'b0;
    w_load_value = 1'b0;
    w_age        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_deq) w_state_nxt = S_UPD;
      end
      S_UPD: begin
        w_ud_valid = 1'b1;
        w_ud_bank  = r_cur.bank;
        w_ud_index = w_prov_idx;
        if (r_cur.mispred) begin
          w_rst_conf   = 1'b1;
          w_load_value = 1'b1;
          w_ud_value   = r_cur.actual;
          if (ud_ready_i)
            w_state_nxt = (r_cur.bank < LP_BANK_SEL_WIDTH'(LP_TOP_BANK)) ? S_ALLOC : w_done_state;
        end else begin
          w_incr_conf = 1'b1;
          w_ud_conf   = w_conf_sat;
          w_incr_use  = (w_conf_sat == P_CONF_WIDTH'(LP_CONF_MAX));
          if (ud_ready_i) w_state_nxt = w_done_state;
        end
      end
      S_ALLOC: begin
        w_ud_valid = 1'b1;
        if (w_found) begin
          w_ud_bank    = w_tgt;
          w_ud_index   = w_tgt_idx;
          w_ud_tag     = w_tgt_tag;
          w_ud_value   = r_cur.actual;
          w_load_tag   = 1'b1;
          w_load_value = 1'b1;
          w_rst_conf   = 1'b1;
          w_rst_use    = 1'b1;
        end else begin
          w_decr_use = 1'b1;
          w_ud_mask  = w_upper_mask;
        end
        if (ud_ready_i) w_state_nxt = w_done_state;
      end
`ifdef VTAGE_UD_AGEING_EN
      S_AGE: begin
        w_ud_valid = 1'b1;
        w_age      = 1'b1;
        if (ud_ready_i) w_state_nxt = S_IDLE;
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign fb_ready_o      = w_fb_ready;
  assign ud_valid_o      = w_ud_valid;
  assign ud_bank_o       = w_ud_bank;
  assign ud_bank_mask_o  = w_ud_mask;
  assign ud_index_o      = w_ud_index;
  assign ud_tag_o        = w_ud_tag;
  assign ud_value_o      = w_ud_value;
  assign ud_conf_o       = w_ud_conf;
  assign ud_incr_conf_o  = w_incr_conf;
  assign ud_rst_conf_o   = w_rst_conf;
  assign ud_incr_use_o   = w_incr_use;
  assign ud_decr_use_o   = w_decr_use;
  assign ud_rst_use_o    = w_rst_use;
  assign ud_load_tag_o   = w_load_tag;
  assign ud_load_value_o = w_load_value;
  assign ud_age_o        = w_age;

endmodule

// File: tb/tb_vtage_update_ctrl_mp.sv
// Directed self-checking bench for vtage_update_ctrl_mp; issued commands are logged at the handshake
// and compared against hand-computed expectations.
module tb_vtage_update_ctrl_mp;

  localparam int unsigned NFB = 2;
  localparam int unsigned NB  = 4;
  localparam int unsigned IW  = 8;
  localparam int unsigned TW  = 12;
  localparam int unsigned VW  = 64;
  localparam int unsigned CW  = 3;
  localparam int unsigned BW  = 2;

  localparam logic [6:0] F_INCR_CONF = 7'b1000000;
  localparam logic [6:0] F_RST_CONF  = 7'b0100000;
  localparam logic [6:0] F_INCR_USE  = 7'b0010000;
  localparam logic [6:0] F_DECR_USE  = 7'b0001000;
  localparam logic [6:0] F_RST_USE   = 7'b0000100;
  localparam logic [6:0] F_LOAD_TAG  = 7'b0000010;
  localparam logic [6:0] F_LOAD_VAL  = 7'b0000001;

`ifdef VTAGE_UD_AGEING_EN
  localparam int unsigned EXP_AGE = 1;
`else
  localparam int unsigned EXP_AGE = 0;
`endif

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic [NFB-1:0]        fb_valid_i;
  logic                  fb_ready_o;
  logic [NFB*VW-1:0]     fb_actual_i;
  logic [NFB*CW-1:0]     fb_conf_i;
  logic [NFB*BW-1:0]     fb_bank_i;
  logic [NFB*NB*IW-1:0]  fb_index_i;
  logic [NFB*NB*TW-1:0]  fb_tag_i;
  logic [NFB-1:0]        fb_mispredict_i;
  logic [NB-1:0]         bank_alloc_avail_i;
  logic                  ud_valid_o;
  logic                  ud_ready_i;
  logic [BW-1:0]         ud_bank_o;
  logic [NB-1:0]         ud_bank_mask_o;
  logic [IW-1:0]         ud_index_o;
  logic [TW-1:0]         ud_tag_o;
  logic [VW-1:0]         ud_value_o;
  logic [CW-1:0]         ud_conf_o;
  logic ud_incr_conf_o, ud_rst_conf_o, ud_incr_use_o, ud_decr_use_o;
  logic ud_rst_use_o, ud_load_tag_o, ud_load_value_o, ud_age_o;

  vtage_update_ctrl_mp #(.P_AGE_LOG2(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .fb_valid_i(fb_valid_i), .fb_ready_o(fb_ready_o),
    .fb_actual_i(fb_actual_i), .fb_conf_i(fb_conf_i), .fb_bank_i(fb_bank_i),
    .fb_index_i(fb_index_i), .fb_tag_i(fb_tag_i), .fb_mispredict_i(fb_mispredict_i),
    .bank_alloc_avail_i(bank_alloc_avail_i),
    .ud_valid_o(ud_valid_o), .ud_ready_i(ud_ready_i),
    .ud_bank_o(ud_bank_o), .ud_bank_mask_o(ud_bank_mask_o), .ud_index_o(ud_index_o),
    .ud_tag_o(ud_tag_o), .ud_value_o(ud_value_o), .ud_conf_o(ud_conf_o),
    .ud_incr_conf_o(ud_incr_conf_o), .ud_rst_conf_o(ud_rst_conf_o),
    .ud_incr_use_o(ud_incr_use_o), .ud_decr_use_o(ud_decr_use_o),
    .ud_rst_use_o(ud_rst_use_o), .ud_load_tag_o(ud_load_tag_o),
    .ud_load_value_o(ud_load_value_o), .ud_age_o(ud_age_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [BW-1:0] bank;
    logic [NB-1:0] mask;
    logic [IW-1:0] index;
    logic [TW-1:0] tag;
    logic [VW-1:0] value;
    logic [CW-1:0] conf;
    logic [6:0]    flags;
    logic          age;
  } cmd_t;

  cmd_t        cmd_log[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned age_seen = 0;
  int unsigned age_pos  = 0;

  function automatic cmd_t live();
    cmd_t c;
    c.bank  = ud_bank_o;
    c.mask  = ud_bank_mask_o;
    c.index = ud_index_o;
    c.tag   = ud_tag_o;
    c.value = ud_value_o;
    c.conf  = ud_conf_o;
    c.flags = {ud_incr_conf_o, ud_rst_conf_o, ud_incr_use_o, ud_decr_use_o,
               ud_rst_use_o, ud_load_tag_o, ud_load_value_o};
    c.age   = ud_age_o;
    return c;
  endfunction

  function automatic cmd_t mk(input int unsigned bank, input int unsigned mask,
                              input logic [IW-1:0] idx, input logic [TW-1:0] tg,
                              input logic [VW-1:0] val, input int unsigned conf,
                              input logic [6:0] fl);
    cmd_t c;
    c.bank = BW'(bank); c.mask = NB'(mask); c.index = idx; c.tag = tg;
    c.value = val; c.conf = CW'(conf); c.flags = fl; c.age = 1'b0;
    return c;
  endfunction

  function automatic logic [IW-1:0] eidx(input int unsigned id, input int unsigned b);
    return IW'(id*4 + b);
  endfunction

  function automatic logic [TW-1:0] etag(input int unsigned id, input int unsigned b);
    return TW'(id*16 + b);
  endfunction

  function automatic logic [VW-1:0] eval(input int unsigned id);
    return 64'h1000 + VW'(id);
  endfunction

  task automatic check(input string tg, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tg, got, exp);
    end
  endtask

  task automatic check_cmd(input string tg, input cmd_t g, input cmd_t e);
    check({tg, ".bank"},  64'(g.bank),  64'(e.bank));
    check({tg, ".mask"},  64'(g.mask),  64'(e.mask));
    check({tg, ".index"}, 64'(g.index), 64'(e.index));
    check({tg, ".tag"},   64'(g.tag),   64'(e.tag));
    check({tg, ".value"}, g.value,      e.value);
    check({tg, ".conf"},  64'(g.conf),  64'(e.conf));
    check({tg, ".flags"}, 64'(g.flags), 64'(e.flags));
    check({tg, ".age"},   64'(g.age),   64'(e.age));
  endtask

  always @(negedge clk_i) begin
    if (!rst_i && ud_valid_o && ud_ready_i) begin
      if (ud_age_o) begin
        age_seen++;
        age_pos = cmd_log.size();
      end else begin
        cmd_log.push_back(live());
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_lane(input int unsigned l, input logic v, input int unsigned id,
                          input int unsigned conf, input int unsigned bank, input logic mis);
    fb_valid_i[l]              = v;
    fb_actual_i[l*VW +: VW]    = eval(id);
    fb_conf_i[l*CW +: CW]      = CW'(conf);
    fb_bank_i[l*BW +: BW]      = BW'(bank);
    fb_mispredict_i[l]         = mis;
    for (int unsigned b = 0; b < NB; b++) begin
      fb_index_i[(l*NB+b)*IW +: IW] = eidx(id, b);
      fb_tag_i[(l*NB+b)*TW +: TW]   = etag(id, b);
    end
  endtask

  task automatic enq();
    int unsigned w = 0;
    while (!fb_ready_o && w < 50) begin
      tick();
      w++;
    end
    if (!fb_ready_o) check("enq.ready", 64'(fb_ready_o), 64'd1);
    tick();
    fb_valid_i = '0;
  endtask

  task automatic wait_log(input int unsigned n, input string tg);
    int unsigned w = 0;
    while (cmd_log.size() < n && w < 300) begin
      tick();
      w++;
    end
    check({tg, ".count"}, 64'(cmd_log.size()), 64'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    int unsigned base;
    logic        was_ready;
    cmd_t        exp_c;

    rst_i = 1'b1; fb_valid_i = '0; fb_actual_i = '0; fb_conf_i = '0; fb_bank_i = '0;
    fb_index_i = '0; fb_tag_i = '0; fb_mispredict_i = '0;
    bank_alloc_avail_i = '0; ud_ready_i = 1'b1;
    tick(); tick();
    check("rst.valid", 64'(ud_valid_o), 64'd0);
    check("rst.ready", 64'(fb_ready_o), 64'd1);
    check_cmd("rst.cmd", live(), mk(0, 0, '0, '0, '0, 0, 7'b0));
    rst_i = 1'b0;

    // Correct prediction reaching saturation, plus one-cycle latch-to-command latency.
    set_lane(0, 1'b1, 1, 6, 2, 1'b0);
    enq();
    tick();
    check("t1.lat", 64'(ud_valid_o), 64'd1);
    wait_log(1, "t1");
    check_cmd("t1", cmd_log[0], mk(2, 0, eidx(1, 2), '0, '0, 7, F_INCR_CONF | F_INCR_USE));

    set_lane(0, 1'b1, 2, 2, 0, 1'b0);
    set_lane(1, 1'b1, 3, 7, 3, 1'b0);
    enq();
    wait_log(3, "t1b");
    check_cmd("t1b.l0", cmd_log[1], mk(0, 0, eidx(2, 0), '0, '0, 3, F_INCR_CONF));
    check_cmd("t1b.l1", cmd_log[2], mk(3, 0, eidx(3, 3), '0, '0, 7, F_INCR_CONF | F_INCR_USE));

    set_lane(0, 1'b0, 0, 0, 0, 1'b0);
    set_lane(1, 1'b1, 4, 0, 1, 1'b0);
    enq();
    wait_log(4, "t1c");
    check_cmd("t1c", cmd_log[3], mk(1, 0, eidx(4, 1), '0, '0, 1, F_INCR_CONF));

    // Mispredict with allocation into the lowest available upper bank.
    bank_alloc_avail_i = 4'b1000;
    set_lane(0, 1'b1, 5, 3, 1, 1'b1);
    set_lane(1, 1'b0, 0, 0, 0, 1'b0);
    enq();
    wait_log(6, "t2");
    check_cmd("t2.upd", cmd_log[4], mk(1, 0, eidx(5, 1), '0, eval(5), 0, F_RST_CONF | F_LOAD_VAL));
    check_cmd("t2.alloc", cmd_log[5], mk(3, 0, eidx(5, 3), etag(5, 3), eval(5), 0,
              F_RST_CONF | F_RST_USE | F_LOAD_TAG | F_LOAD_VAL));

    bank_alloc_avail_i = 4'b1011;
    set_lane(0, 1'b1, 6, 5, 1, 1'b1);
    enq();
    wait_log(8, "t2b");
    check_cmd("t2b.alloc", cmd_log[7], mk(3, 0, eidx(6, 3), etag(6, 3), eval(6), 0,
              F_RST_CONF | F_RST_USE | F_LOAD_TAG | F_LOAD_VAL));

    bank_alloc_avail_i = 4'b0110;
    set_lane(0, 1'b1, 9, 1, 0, 1'b1);
    enq();
    wait_log(10, "t2c");
    check_cmd("t2c.alloc", cmd_log[9], mk(1, 0, eidx(9, 1), etag(9, 1), eval(9), 0,
              F_RST_CONF | F_RST_USE | F_LOAD_TAG | F_LOAD_VAL));

    // No bank free: decrement useful across the banks above the provider.
    bank_alloc_avail_i = 4'b0000;
    set_lane(0, 1'b1, 7, 2, 1, 1'b1);
    enq();
    wait_log(12, "t3");
    check_cmd("t3.decr", cmd_log[11], mk(0, 4'b1100, '0, '0, '0, 0, F_DECR_USE));

    // Mispredict in the top bank has nowhere to allocate.
    set_lane(0, 1'b1, 8, 4, 3, 1'b1);
    enq();
    wait_log(13, "t3b");
    repeat (10) tick();
    check("t3b.single", 64'(cmd_log.size()), 64'd13);
    check_cmd("t3b.upd", cmd_log[12], mk(3, 0, eidx(8, 3), '0, eval(8), 0, F_RST_CONF | F_LOAD_VAL));

    // Fill under backpressure, then drain in order.
    ud_ready_i = 1'b0;
    n = 20;
    for (int unsigned c = 0; c < 12; c++) begin
      set_lane(0, 1'b1, n, 1, n % 4, 1'b0);
      set_lane(1, 1'b1, n + 1, 1, (n + 1) % 4, 1'b0);
      was_ready = fb_ready_o;
      tick();
      if (was_ready) n += 2;
    end
    fb_valid_i = '0;
    check("t4.accepted", 64'(n - 20), 64'd8);
    check("t4.full", 64'(fb_ready_o), 64'd0);
    check("t4.stallvalid", 64'(ud_valid_o), 64'd1);
    base = cmd_log.size();
    ud_ready_i = 1'b1;
    wait_log(base + 8, "t4");
    for (int unsigned k = 0; k < 8; k++)
      check_cmd($sformatf("t4.%0d", k), cmd_log[base + k],
                mk((20 + k) % 4, 0, eidx(20 + k, (20 + k) % 4), '0, '0, 2, F_INCR_CONF));
    check("t4.drained", 64'(fb_ready_o), 64'd1);

    // Fields stable while stalled, then reset in the middle of ALLOC.
    ud_ready_i = 1'b0;
    bank_alloc_avail_i = 4'b1000;
    set_lane(0, 1'b1, 30, 0, 1, 1'b1);
    enq();
    n = 0;
    while (!ud_valid_o && n < 20) begin
      tick();
      n++;
    end
    exp_c = mk(1, 0, eidx(30, 1), '0, eval(30), 0, F_RST_CONF | F_LOAD_VAL);
    for (int unsigned k = 0; k < 3; k++) begin
      check_cmd($sformatf("t5.upd%0d", k), live(), exp_c);
      tick();
    end
    ud_ready_i = 1'b1;
    tick();
    ud_ready_i = 1'b0;
    exp_c = mk(3, 0, eidx(30, 3), etag(30, 3), eval(30), 0,
               F_RST_CONF | F_RST_USE | F_LOAD_TAG | F_LOAD_VAL);
    check_cmd("t5.alloc0", live(), exp_c);
    tick();
    bank_alloc_avail_i = 4'b0100;
    check_cmd("t5.alloc1", live(), exp_c);
    set_lane(0, 1'b1, 31, 0, 0, 1'b0);
    set_lane(1, 1'b1, 32, 0, 0, 1'b0);
    enq();
    check_cmd("t5.alloc2", live(), exp_c);
    rst_i = 1'b1;
    tick();
    check("t5.rstvalid", 64'(ud_valid_o), 64'd0);
    check("t5.rstready", 64'(fb_ready_o), 64'd1);
    rst_i = 1'b0;
    ud_ready_i = 1'b1;
    bank_alloc_avail_i = '0;
    base = cmd_log.size();
    repeat (10) tick();
    check("t5.empty", 64'(cmd_log.size()), 64'(base));

    // Four top-bank mispredicts: with ageing built in, one age command follows the fourth.
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    age_seen = 0;
    base = cmd_log.size();
    for (int unsigned k = 0; k < 4; k++) begin
      set_lane(0, 1'b1, 40 + k, 0, 3, 1'b1);
      set_lane(1, 1'b0, 0, 0, 0, 1'b0);
      enq();
      wait_log(base + k + 1, $sformatf("age.m%0d", k));
    end
    repeat (10) tick();
    check("age.count", 64'(age_seen), 64'(EXP_AGE));
`ifdef VTAGE_UD_AGEING_EN
    check("age.pos", 64'(age_pos), 64'(base + 4));
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
